alu_ctrl_seq: RTL and testbench

// Registered, handshaked ALU control stage for the pipelined RV32IM core. Decodes
// {funct7, ALU_Op, funct3} from the ID stage into an ALU operation code. Adds M-extension
// and SRA/SLT decoding. Sequences multi-cycle MUL/DIV ops by stalling upstream until the

---
 rtl/alu_ctrl_seq_pkg.sv | 58 +++++
 rtl/alu_ctrl_decode.sv | 87 ++++++++
 rtl/alu_ctrl_seq.sv | 129 ++++++++++++
 tb/tb_alu_ctrl_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_seq_pkg.sv
// Shared ALU-control definitions: instruction classes, op code table, decode record.
// No logic; used by the control stage, the ALU and the muldiv unit.
// Keep the op code table in sync with the ALU's case statement.
package alu_ctrl_seq_pkg;

  // ALU_Op instruction classes from the ID stage
  localparam logic [2:0] CLS_R    = 3'b000;
  localparam logic [2:0] CLS_I    = 3'b001;
  localparam logic [2:0] CLS_LUI  = 3'b010;
  localparam logic [2:0] CLS_B    = 3'b011;
  localparam logic [2:0] CLS_LW   = 3'b100;
  localparam logic [2:0] CLS_SW   = 3'b101;
  localparam logic [2:0] CLS_JAL  = 3'b110;
  localparam logic [2:0] CLS_JALR = 3'b111;

  // funct7 values that carry meaning
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALU op code table (zero-extended to OP_W at the port)
  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_LUI    = 5'h01;
  localparam logic [4:0] OP_OR     = 5'h01;
  localparam logic [4:0] OP_ORI    = 5'h02;
  localparam logic [4:0] OP_SLL    = 5'h03;
  localparam logic [4:0] OP_SRL    = 5'h04;
  localparam logic [4:0] OP_SUB    = 5'h05;
  localparam logic [4:0] OP_AND    = 5'h06;
  localparam logic [4:0] OP_XOR    = 5'h07;
  localparam logic [4:0] OP_BEQ    = 5'h08;
  localparam logic [4:0] OP_BNE    = 5'h09;
  localparam logic [4:0] OP_BGE    = 5'h0A;
  localparam logic [4:0] OP_BLT    = 5'h0B;
  localparam logic [4:0] OP_JAL    = 5'h0C;
  localparam logic [4:0] OP_JALR   = 5'h0D;
  localparam logic [4:0] OP_LW     = 5'h0E;
  localparam logic [4:0] OP_SW     = 5'h0F;
  localparam logic [4:0] OP_MUL    = 5'h10;  // MUL..REMU are OP_MUL + funct3
  localparam logic [4:0] OP_SRA    = 5'h18;
  localparam logic [4:0] OP_SLT    = 5'h19;
  localparam logic [4:0] OP_SLTU   = 5'h1A;

  // Result of decoding one instruction
  typedef struct packed {
    logic [4:0] op;
    logic       multicycle;
    logic       is_div;
    logic       illegal;
  } dec_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Purpose: combinational {funct7, alu_op, funct3} -> {op, multicycle, is_div, illegal}.
// Latency: zero cycles (pure logic).
// Backpressure: none; the enclosing stage decides when the result is captured.
module alu_ctrl_decode
  import alu_ctrl_seq_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [6:0] funct7,
  input  logic [2:0] alu_op,
  input  logic [2:0] funct3,
  output dec_t       dec
);

  // Table decode; anything unmatched leaves op=0 and raises illegal.
  // LUI/LW/SW/JAL/JALR are decoded on class alone.
  always_comb begin
    dec = '0;
    case (alu_op)
      CLS_R: begin
        case (funct7)
          F7_BASE: begin
            case (funct3)
              3'b000:  dec.op = OP_ADD;
              3'b001:  dec.op = OP_SLL;
              3'b010:  dec.op = OP_SLT;
              3'b011:  dec.op = OP_SLTU;
              3'b100:  dec.op = OP_XOR;
              3'b101:  dec.op = OP_SRL;
              3'b110:  dec.op = OP_OR;
              default: dec.op = OP_AND;
            endcase
          end
          F7_ALT: begin
            if (funct3 == 3'b000)      dec.op = OP_SUB;
            else if (funct3 == 3'b101) dec.op = OP_SRA;
            else                       dec.illegal = 1'b1;
          end
          F7_MULDIV: begin
            if (ENABLE_M) begin
              dec.op         = OP_MUL | {2'b00, funct3};
              dec.multicycle = 1'b1;
              dec.is_div     = funct3[2];
            end else begin
              dec.illegal = 1'b1;
            end
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      CLS_I: begin
        case (funct3)
          3'b000: dec.op = OP_ADD;
          3'b001: begin
            if (funct7 == F7_BASE) dec.op = OP_SLL;
            else                   dec.illegal = 1'b1;
          end
          3'b010: dec.op = OP_SLT;
          3'b011: dec.op = OP_SLTU;
          3'b100: dec.op = OP_XOR;
          3'b101: begin
            if (funct7 == F7_BASE)     dec.op = OP_SRL;
            else if (funct7 == F7_ALT) dec.op = OP_SRA;
            else                       dec.illegal = 1'b1;
          end
          3'b110:  dec.op = OP_ORI;
          default: dec.op = OP_AND;
        endcase
      end
      CLS_LUI: dec.op = OP_LUI;
      CLS_B: begin
        case (funct3)
          3'b000:  dec.op = OP_BEQ;
          3'b001:  dec.op = OP_BNE;
          3'b100:  dec.op = OP_BLT;
          3'b101:  dec.op = OP_BGE;
          default: dec.illegal = 1'b1;
        endcase
      end
      CLS_LW:  dec.op = OP_LW;
      CLS_SW:  dec.op = OP_SW;
      CLS_JAL: dec.op = OP_JAL;
      default: dec.op = OP_JALR;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Purpose: registered valid/ready ALU control stage; sequences multi-cycle MUL/DIV.
// Latency: 1 cycle for single-cycle ops, MUL_CYCLES for MUL*, DIV_CYCLES for DIV*/REM*.
// Backpressure: holds its output while ready_i=0; stalls upstream (ready_o=0) while counting.
module alu_ctrl_seq
  import alu_ctrl_seq_pkg::*;
#(
  parameter int OP_W       = 5,
  parameter bit ENABLE_M   = 1'b1,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      alu_op_i,
  input  logic [2:0]      funct3_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [OP_W-1:0] alu_operation_o,
  output logic            multicycle_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            illegal_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  // BUSY lasts CYCLES-1 cycles: counter loads CYCLES-2 and leaves at zero.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);

  dec_t             dec;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       op_q, op_d;
  logic             mc_q, mc_d;
  logic             ill_q, ill_d;
  logic             done_q, done_d;
  logic             needs_busy;

  alu_ctrl_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .funct7 (funct7_i),
    .alu_op (alu_op_i),
    .funct3 (funct3_i),
    .dec    (dec)
  );

  assign needs_busy = dec.multicycle &&
                      (dec.is_div ? (DIV_CYCLES > 1) : (MUL_CYCLES > 1));

  // Next state, counter and capture; reset and flush override the handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    mc_d    = mc_q;
    ill_d   = ill_q;
    done_d  = 1'b0;
    ready_o = 1'b0;

    case (state_q)
      ST_EMPTY: ready_o = 1'b1;
      ST_FULL: begin
        ready_o = ready_i;
        if (ready_i && !valid_i) state_d = ST_EMPTY;
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_FULL;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (reset || flush_i) ready_o = 1'b0;

    if (valid_i && ready_o) begin
      op_d  = dec.op;
      mc_d  = dec.multicycle;
      ill_d = dec.illegal;
      if (needs_busy) begin
        state_d = ST_BUSY;
        cnt_d   = dec.is_div ? DIV_LOAD : MUL_LOAD;
      end else begin
        state_d = ST_FULL;
      end
    end

    if (flush_i) begin
      state_d = ST_EMPTY;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  // State and output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
      op_q    <= '0;
      mc_q    <= 1'b0;
      ill_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      mc_q    <= mc_d;
      ill_q   <= ill_d;
      done_q  <= done_d;
    end
  end

  assign valid_o         = (state_q == ST_FULL);
  assign busy_o          = (state_q == ST_BUSY);
  assign done_o          = done_q;
  assign alu_operation_o = OP_W'(op_q);
  assign multicycle_o    = mc_q;
  assign illegal_o       = ill_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Purpose: bench for alu_ctrl_seq (ENABLE_M=1 and ENABLE_M=0 instances on shared inputs).
// Latency: reference tracks each held op by the absolute cycle its result is due.
// Backpressure: random ready_i, flush_i and reset exercise stall, hold and kill paths.
module tb_alu_ctrl_seq;

  localparam int MUL_C = 4;
  localparam int DIV_C = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_i;
  logic       ready_i;
  logic       flush_i;
  logic [6:0] funct7_i;
  logic [2:0] alu_op_i;
  logic [2:0] funct3_i;

  logic [1:0] v_o, r_o, b_o, d_o, mc_o, il_o;
  logic [4:0] op_o [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference state per instance: what is held and when its result is due
  bit         m_have [2];
  int         m_due  [2];
  int         m_lat  [2];
  logic [4:0] m_code [2];
  bit         m_ill  [2];
  bit         m_mc   [2];

  logic [4:0] r_tab [8];
  logic [4:0] i_tab [8];

  always #5 clk = ~clk;

  alu_ctrl_seq #(.OP_W(5), .ENABLE_M(1'b1), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut_m (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(r_o[0]),
    .funct7_i(funct7_i), .alu_op_i(alu_op_i), .funct3_i(funct3_i), .flush_i(flush_i),
    .valid_o(v_o[0]), .ready_i(ready_i), .alu_operation_o(op_o[0]),
    .multicycle_o(mc_o[0]), .busy_o(b_o[0]), .done_o(d_o[0]), .illegal_o(il_o[0]));

  alu_ctrl_seq #(.OP_W(5), .ENABLE_M(1'b0), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut_nom (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(r_o[1]),
    .funct7_i(funct7_i), .alu_op_i(alu_op_i), .funct3_i(funct3_i), .flush_i(flush_i),
    .valid_o(v_o[1]), .ready_i(ready_i), .alu_operation_o(op_o[1]),
    .multicycle_o(mc_o[1]), .busy_o(b_o[1]), .done_o(d_o[1]), .illegal_o(il_o[1]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference decode: kind 0 = single cycle, 1 = multiply, 2 = divide/remainder
  task automatic ref_dec(input logic [6:0] f7, input logic [2:0] aop, input logic [2:0] f3,
                         input bit en_m, output logic [4:0] code, output bit ill, output int kind);
    code = 5'h00; ill = 1'b0; kind = 0;
    case (aop)
      3'd0: begin
        if (f7 == 7'h00) code = r_tab[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) code = 5'h05;
        else if (f7 == 7'h20 && f3 == 3'd5) code = 5'h18;
        else if (f7 == 7'h01 && en_m) begin
          code = 5'(16 + int'(f3));
          kind = (f3 >= 3'd4) ? 2 : 1;
        end else ill = 1'b1;
      end
      3'd1: begin
        if ((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) ill = 1'b1;
        else if (f3 == 3'd5 && f7 == 7'h20) code = 5'h18;
        else code = i_tab[f3];
      end
      3'd2: code = 5'h01;
      3'd3: begin
        case (f3)
          3'd0: code = 5'h08;
          3'd1: code = 5'h09;
          3'd4: code = 5'h0B;
          3'd5: code = 5'h0A;
          default: ill = 1'b1;
        endcase
      end
      3'd4: code = 5'h0E;
      3'd5: code = 5'h0F;
      3'd6: code = 5'h0C;
      default: code = 5'h0D;
    endcase
  endtask

  // Compare one instance against the reference for this cycle, then advance the reference
  task automatic model_cycle(input int k);
    bit ev, eb, ed, er, il;
    logic [4:0] c;
    int kind;
    ev = m_have[k] && cyc >= m_due[k];
    eb = m_have[k] && cyc < m_due[k];
    ed = m_have[k] && m_lat[k] > 1 && cyc == m_due[k];
    er = !reset && !flush_i && (!m_have[k] || (ev && ready_i));
    check_eq($sformatf("valid_o[%0d]", k), 32'(v_o[k]), 32'(ev));
    check_eq($sformatf("busy_o[%0d]", k), 32'(b_o[k]), 32'(eb));
    check_eq($sformatf("done_o[%0d]", k), 32'(d_o[k]), 32'(ed));
    check_eq($sformatf("ready_o[%0d]", k), 32'(r_o[k]), 32'(er));
    if (ev) begin
      check_eq($sformatf("alu_operation_o[%0d]", k), 32'(op_o[k]), 32'(m_code[k]));
      check_eq($sformatf("illegal_o[%0d]", k), 32'(il_o[k]), 32'(m_ill[k]));
      check_eq($sformatf("multicycle_o[%0d]", k), 32'(mc_o[k]), 32'(m_mc[k]));
    end
    if (reset || flush_i) begin
      m_have[k] = 1'b0;
    end else if (valid_i && er) begin
      ref_dec(funct7_i, alu_op_i, funct3_i, (k == 0), c, il, kind);
      m_have[k] = 1'b1;
      m_code[k] = c;
      m_ill[k]  = il;
      m_mc[k]   = (kind != 0);
      m_lat[k]  = (kind == 1) ? MUL_C : (kind == 2) ? DIV_C : 1;
      m_due[k]  = cyc + m_lat[k];
    end else if (ev && ready_i) begin
      m_have[k] = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) model_cycle(k);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input bit v, input logic [6:0] f7, input logic [2:0] aop, input logic [2:0] f3);
    valid_i = v; funct7_i = f7; alu_op_i = aop; funct3_i = f3;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    r_tab = '{5'h00, 5'h03, 5'h19, 5'h1A, 5'h07, 5'h04, 5'h01, 5'h06};
    i_tab = '{5'h00, 5'h03, 5'h19, 5'h1A, 5'h07, 5'h04, 5'h02, 5'h06};
    reset = 1'b1; ready_i = 1'b1; flush_i = 1'b0;
    put(0, 7'h00, 3'd0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) m_have[k] = 1'b0;
    step();                                  // reset still high: ready_o must be 0
    reset = 1'b0;
    step();                                  // first cycle out of reset: ready_o=1

    // back-to-back ADD, SUB, ANDI
    put(1, 7'h00, 3'd0, 3'd0); step();
    put(1, 7'h20, 3'd0, 3'd0); step();
    put(1, 7'h00, 3'd1, 3'd7); step();
    put(0, 7'h00, 3'd0, 3'd0); repeat (3) step();

    // MUL then DIVU
    put(1, 7'h01, 3'd0, 3'd0); step();
    put(0, 7'h00, 3'd0, 3'd0); repeat (6) step();
    put(1, 7'h01, 3'd0, 3'd5); step();
    put(0, 7'h00, 3'd0, 3'd0); repeat (34) step();

    // BEQ held under backpressure while BNE waits
    put(1, 7'h00, 3'd3, 3'd0); step();
    ready_i = 1'b0; put(1, 7'h00, 3'd3, 3'd1); repeat (5) step();
    ready_i = 1'b1; step();
    put(0, 7'h00, 3'd0, 3'd0); repeat (3) step();

    // flush during REM countdown, valid_i presented in the flush cycle
    put(1, 7'h01, 3'd0, 3'd6); step();
    put(0, 7'h00, 3'd0, 3'd0); repeat (5) step();
    flush_i = 1'b1; put(1, 7'h00, 3'd0, 3'd0); step();
    flush_i = 1'b0; put(0, 7'h00, 3'd0, 3'd0); repeat (40) step();

    // flush while FULL and stalled
    ready_i = 1'b0; put(1, 7'h00, 3'd3, 3'd0); step();
    put(0, 7'h00, 3'd0, 3'd0); step();
    flush_i = 1'b1; put(1, 7'h00, 3'd0, 3'd0); step();
    flush_i = 1'b0; ready_i = 1'b1; put(0, 7'h00, 3'd0, 3'd0); repeat (3) step();

    // reset in the middle of a DIV countdown (counter at 10)
    put(1, 7'h01, 3'd0, 3'd4); step();
    put(0, 7'h00, 3'd0, 3'd0); repeat (20) step();
    reset = 1'b1; step();
    reset = 1'b0; repeat (2) step();

    // R-type with an undefined funct7
    put(1, 7'h02, 3'd0, 3'd0); step();
    put(0, 7'h00, 3'd0, 3'd0); repeat (2) step();

    // randomized traffic
    repeat (3000) begin
      logic [6:0] f7;
      case ($urandom_range(0, 4))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        3: f7 = 7'h00;
        default: f7 = 7'($urandom);
      endcase
      put(($urandom_range(0, 9) < 7), f7, 3'($urandom), 3'($urandom));
      ready_i = ($urandom_range(0, 9) < 8);
      flush_i = ($urandom_range(0, 29) == 0);
      reset   = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    put(0, 7'h00, 3'd0, 3'd0); repeat (40) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
